true_dpr_be: RTL and testbench
==============================

Name: true_dpr_be

Overview:
- Single-clock true dual-port RAM. Generalises the two-clock dual-port RAM with per-byte write enables, a selectable read-during-write mode, an optional output register stage and read-valid tracking.
- Both ports (A, B) can read or write any address every cycle.
- Same-cycle write collisions are resolved deterministically and flagged.
- Used as register-file/buffer storage in single-clock-domain datapaths.

Parameters:
- DATA_WIDTH, 32, word width in bits. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one write-enable lane.
- ADDR_WIDTH, 8, address width. Depth = 2**ADDR_WIDTH.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data), 2 = no-change (q holds).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_en  in  1  port A access enable.
- a_be  in  DATA_WIDTH/BYTE_WIDTH  port A byte write enables; write only when a_en=1.
- a_addr  in  ADDR_WIDTH  port A address.
- a_data  in  DATA_WIDTH  port A write data.
- a_q  out  DATA_WIDTH  port A read data.
- a_q_valid  out  1  a_q holds the result of an access.
- b_en, b_be, b_addr, b_data, b_q, b_q_valid  same as port A, for port B.
- collision  out  1  registered pulse: both ports wrote the same address with overlapping byte enables.

Behaviour:
- Reset (rst=0, asynchronous):
  - a_q, b_q, a_q_valid, b_q_valid, collision and all pipeline registers go to 0 immediately.
  - Memory array is not reset; contents are preserved across reset.
  - No write occurs while rst=0.
  - After rst deasserts, the first edge with en=1 is a normal access.
- Access: en=1 with be=0 is a read. en=1 with be!=0 is a write to the enabled lanes plus a read per RDW_MODE. en=0 means no access and q holds.
- Write merge: lane i of mem[addr] takes data[i*BYTE_WIDTH +: BYTE_WIDTH] when be[i]=1; other lanes keep their old value.
- Latency:
  - OUT_REG=0: q and q_valid update at the edge after the access.
  - OUT_REG=1: one extra cycle; stage-2 register follows stage 1 every cycle.
  - q_valid = en delayed by the same latency, except that with RDW_MODE=2 and be!=0, q_valid=0 for that access.
- Same-port read-during-write:
  - mode 0: q = word before the write.
  - mode 1: q = merged word after the write.
  - mode 2: q keeps its previous value.
- Cross-port read of an address written by the other port in the same cycle: always returns the old word. The new word is visible from the next access.
- Write collision (both en, both be!=0, a_addr==b_addr):
  - Lanes enabled on A only are written by A.
  - Lanes enabled on B only are written by B.
  - Lanes enabled on both are written by A (A priority).
  - collision=1 for one cycle (at the next edge) only if (a_be & b_be)!=0. Otherwise collision=0.
  - Each port's own read result follows RDW_MODE against the final merged word; port B's mode-1 read shows A's winning lanes.
- Wrap-around: addresses are exactly ADDR_WIDTH bits; no out-of-range addresses exist.
- Reset mid-operation: in-flight reads in the OUT_REG stage are discarded (valid=0). A write on the same edge as rst falling is not performed.

Test Plan:
- Reset/persist: write A addr 0x10=0xDEADBEEF, then pulse rst low 3 cycles -> a_q=0 and a_q_valid=0 during reset; after reset, a read of 0x10 -> 0xDEADBEEF with valid, latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Byte enables: mem[0x05]=0x11223344; A writes 0xAABBCCDD with a_be=4'b0101 -> a following read returns 0x11BB33DD.
- RDW modes: mem[0x20]=0x1; A writes 0x2 with be=1111 and reads the same cycle -> mode0 a_q=0x1, mode1 a_q=0x2, mode2 a_q unchanged and a_q_valid=0.
- Cross-port: A writes 0x55 to 0x30 while B reads 0x30 (old 0x00) -> b_q=0x00; B reads 0x30 next cycle -> 0x55.
- Collision: A writes 0x000000AA be=0001, B writes 0x0000BBCC be=0011, both to 0x40 -> mem[0x40]=0x0000BBAA; collision=1 for exactly one cycle. Repeat with disjoint be=0001 and 0010 -> collision=0.
- Back-to-back: both ports stream 256 random reads/writes every cycle against a reference model -> every q and q_valid matches, no bubbles.

Source files
------------

// File: rtl/true_dpr_be.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// same-port read-during-write behaviour, optional output register and write-collision flag.
module true_dpr_be #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             a_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH-1:0]            a_data,
    output logic [DATA_WIDTH-1:0]            a_q,
    output logic                             a_q_valid,
    input  logic                             b_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH-1:0]            b_data,
    output logic [DATA_WIDTH-1:0]            b_q,
    output logic                             b_q_valid,
    output logic                             collision
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [DATA_WIDTH-1:0] r_a_q1, r_a_q2, r_b_q1, r_b_q2;
    logic                  r_a_v1, r_a_v2, r_b_v1, r_b_v2;
    logic                  r_collision;

    logic                  w_a_wr, w_b_wr, w_same;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old, w_a_merged, w_b_merged;
    logic [DATA_WIDTH-1:0] w_a_rd_word, w_b_rd_word;
    logic                  w_a_hold, w_b_hold;

    // Lanes from the priority source win over the secondary source; untouched lanes keep old data.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] pri_data,
        input logic [NB-1:0]         pri_be,
        input logic [DATA_WIDTH-1:0] sec_data,
        input logic [NB-1:0]         sec_be
    );
        logic [DATA_WIDTH-1:0] word;
        word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (pri_be[i]) begin
                word[i*BYTE_WIDTH +: BYTE_WIDTH] = pri_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (sec_be[i]) begin
                word[i*BYTE_WIDTH +: BYTE_WIDTH] = sec_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                word[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return word;
    endfunction

    assign w_a_wr  = a_en && (a_be != {NB{1'b0}});
    assign w_b_wr  = b_en && (b_be != {NB{1'b0}});
    assign w_same  = (a_addr == b_addr);
    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    // On a same-address double write both ports compute the identical final word (A priority).
    assign w_a_merged = merge_lanes(w_a_old, a_data, a_be, b_data,
                                    (w_b_wr && w_same) ? b_be : {NB{1'b0}});
    assign w_b_merged = merge_lanes(w_b_old, a_data, (w_a_wr && w_same) ? a_be : {NB{1'b0}},
                                    b_data, b_be);

    assign w_a_rd_word = (RDW_MODE == 32'sd1 && w_a_wr) ? w_a_merged : w_a_old;
    assign w_b_rd_word = (RDW_MODE == 32'sd1 && w_b_wr) ? w_b_merged : w_b_old;
    assign w_a_hold    = (RDW_MODE == 32'sd2) && w_a_wr;
    assign w_b_hold    = (RDW_MODE == 32'sd2) && w_b_wr;

    // Storage array: deliberately not reset, and writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_b_wr) r_mem[b_addr] <= w_b_merged;
            if (w_a_wr) r_mem[a_addr] <= w_a_merged;
        end
    end

    // Port A read pipeline: stage 1 captures the access result, stage 2 follows it every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_q1 <= {DATA_WIDTH{1'b0}};
            r_a_v1 <= 1'b0;
            r_a_q2 <= {DATA_WIDTH{1'b0}};
            r_a_v2 <= 1'b0;
        end else begin
            if (a_en && !w_a_hold) r_a_q1 <= w_a_rd_word;
            r_a_v1 <= a_en && !w_a_hold;
            r_a_q2 <= r_a_q1;
            r_a_v2 <= r_a_v1;
        end
    end

    // Port B read pipeline, mirror of port A.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b_q1 <= {DATA_WIDTH{1'b0}};
            r_b_v1 <= 1'b0;
            r_b_q2 <= {DATA_WIDTH{1'b0}};
            r_b_v2 <= 1'b0;
        end else begin
            if (b_en && !w_b_hold) r_b_q1 <= w_b_rd_word;
            r_b_v1 <= b_en && !w_b_hold;
            r_b_q2 <= r_b_q1;
            r_b_v2 <= r_b_v1;
        end
    end

    // Collision pulse: only overlapping lanes on the same address count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= a_en && b_en && w_same && ((a_be & b_be) != {NB{1'b0}});
        end
    end

    assign a_q       = (OUT_REG != 32'sd0) ? r_a_q2 : r_a_q1;
    assign a_q_valid = (OUT_REG != 32'sd0) ? r_a_v2 : r_a_v1;
    assign b_q       = (OUT_REG != 32'sd0) ? r_b_q2 : r_b_q1;
    assign b_q_valid = (OUT_REG != 32'sd0) ? r_b_v2 : r_b_v1;
    assign collision = r_collision;

endmodule

// File: tb/tb_true_dpr_be.sv
// Self-checking bench for true_dpr_be: three instances (read-first/latency 1,
// write-first/latency 2, no-change/latency 1) checked every cycle against a word-level model.
module tb_true_dpr_be;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_be, b_be;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic [31:0] aq [NI];
    logic [31:0] bq [NI];
    logic        av [NI];
    logic        bv [NI];
    logic        col [NI];

    int n_cmp = 0;
    int n_mis = 0;

    // reference state
    logic [31:0] mem_m [256];
    logic [31:0] s1_aq [NI];
    logic [31:0] s2_aq [NI];
    logic [31:0] s1_bq [NI];
    logic [31:0] s2_bq [NI];
    logic        s1_av [NI];
    logic        s2_av [NI];
    logic        s1_bv [NI];
    logic        s2_bv [NI];
    logic        exp_col;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        true_dpr_be #(
            .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8),
            .RDW_MODE(g), .OUT_REG((g == 1) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst),
            .a_en(a_en), .a_be(a_be), .a_addr(a_addr), .a_data(a_data),
            .a_q(aq[g]), .a_q_valid(av[g]),
            .b_en(b_en), .b_be(b_be), .b_addr(b_addr), .b_data(b_data),
            .b_q(bq[g]), .b_q_valid(bv[g]),
            .collision(col[g])
        );
    end

    function automatic bit outreg_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d a_q", k), aq[k], outreg_of(k) ? s2_aq[k] : s1_aq[k]);
            chk($sformatf("u%0d a_q_valid", k), 32'(av[k]), 32'(outreg_of(k) ? s2_av[k] : s1_av[k]));
            chk($sformatf("u%0d b_q", k), bq[k], outreg_of(k) ? s2_bq[k] : s1_bq[k]);
            chk($sformatf("u%0d b_q_valid", k), 32'(bv[k]), 32'(outreg_of(k) ? s2_bv[k] : s1_bv[k]));
            chk($sformatf("u%0d collision", k), 32'(col[k]), 32'(exp_col));
        end
    endtask

    // What one port observes for one access, given the word before and after the edge.
    task automatic port_model(input int mode, input logic en, input logic [3:0] be,
                              input logic [31:0] old_w, input logic [31:0] new_w,
                              input logic [31:0] q_prev, output logic [31:0] q, output logic v);
        if (!en) begin
            q = q_prev; v = 1'b0;
        end else if (be == 4'h0) begin
            q = old_w; v = 1'b1;
        end else if (mode == 0) begin
            q = old_w; v = 1'b1;
        end else if (mode == 1) begin
            q = new_w; v = 1'b1;
        end else begin
            q = q_prev; v = 1'b0;
        end
    endtask

    task automatic step(input bit do_chk,
                        input logic ae, input logic [3:0] abe, input logic [7:0] aad, input logic [31:0] ad,
                        input logic be_, input logic [3:0] bbe, input logic [7:0] bad, input logic [31:0] bd);
        logic [31:0] nxt [256];
        logic [31:0] q;
        logic        v;
        a_en = ae; a_be = abe; a_addr = aad; a_data = ad;
        b_en = be_; b_be = bbe; b_addr = bad; b_data = bd;
        nxt = mem_m;
        // B lanes first, then A lanes on top: A wins shared lanes
        if (be_) for (int i = 0; i < 4; i++) if (bbe[i]) nxt[bad][i*8 +: 8] = bd[i*8 +: 8];
        if (ae)  for (int i = 0; i < 4; i++) if (abe[i]) nxt[aad][i*8 +: 8] = ad[i*8 +: 8];
        for (int k = 0; k < NI; k++) begin
            s2_aq[k] = s1_aq[k]; s2_av[k] = s1_av[k];
            s2_bq[k] = s1_bq[k]; s2_bv[k] = s1_bv[k];
            port_model(k, ae, abe, mem_m[aad], nxt[aad], s1_aq[k], q, v);
            s1_aq[k] = q; s1_av[k] = v;
            port_model(k, be_, bbe, mem_m[bad], nxt[bad], s1_bq[k], q, v);
            s1_bq[k] = q; s1_bv[k] = v;
        end
        exp_col = ae && be_ && (aad == bad) && ((abe & bbe) != 4'h0);
        mem_m = nxt;
        @(posedge clk);
        @(negedge clk);
        if (do_chk) compare_all();
    endtask

    // Holds reset for n cycles while presenting writes that must not land.
    task automatic do_reset(input int n);
        a_en = 1'b1; a_be = 4'hF; a_addr = 8'h10; a_data = 32'hBAD0BAD0;
        b_en = 1'b1; b_be = 4'hF; b_addr = 8'h11; b_data = 32'h0BAD0BAD;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            s1_aq[k] = 32'h0; s2_aq[k] = 32'h0; s1_bq[k] = 32'h0; s2_bq[k] = 32'h0;
            s1_av[k] = 1'b0;  s2_av[k] = 1'b0;  s1_bv[k] = 1'b0;  s2_bv[k] = 1'b0;
        end
        exp_col = 1'b0;
        #1;
        compare_all();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        a_en = 1'b0; b_en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        logic [7:0] aad, bad;
        for (int c = 0; c < cycles; c++) begin
            aad = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'hC0 + $urandom_range(0, 3));
            bad = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'hC0 + $urandom_range(0, 3));
            step(1'b1, $urandom_range(0, 9) != 0, 4'($urandom), aad, $urandom,
                       $urandom_range(0, 9) != 0, 4'($urandom), bad, $urandom);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_en = 1'b0; a_be = 4'h0; a_addr = 8'h0; a_data = 32'h0;
        b_en = 1'b0; b_be = 4'h0; b_addr = 8'h0; b_data = 32'h0;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        for (int k = 0; k < NI; k++) begin
            s1_aq[k] = 32'h0; s2_aq[k] = 32'h0; s1_bq[k] = 32'h0; s2_bq[k] = 32'h0;
            s1_av[k] = 1'b0;  s2_av[k] = 1'b0;  s1_bv[k] = 1'b0;  s2_bv[k] = 1'b0;
        end
        exp_col = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // bring the array to a known all-zero state
        for (int i = 0; i < 128; i++)
            step(1'b0, 1'b1, 4'hF, 8'(2*i), 32'h0, 1'b1, 4'hF, 8'(2*i+1), 32'h0);

        // reset persistence, including writes attempted during reset
        step(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 4'h0, 8'h00, 32'h0);
        do_reset(3);
        step(1'b1, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 4'h0, 8'h11, 32'h0);
        chk("persist a_q", aq[0], 32'hDEADBEEF);
        chk("persist a_q_valid", 32'(av[0]), 32'h1);
        chk("no write in reset", bq[0], 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
        chk("persist latency2", aq[1], 32'hDEADBEEF);

        // byte-lane merge
        step(1'b1, 1'b1, 4'hF, 8'h05, 32'h11223344, 1'b0, 4'h0, 8'h0, 32'h0);
        step(1'b1, 1'b1, 4'b0101, 8'h05, 32'hAABBCCDD, 1'b0, 4'h0, 8'h0, 32'h0);
        step(1'b1, 1'b1, 4'h0, 8'h05, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
        chk("byte merge", aq[0], 32'h11BB33DD);

        // same-port read-during-write
        step(1'b1, 1'b1, 4'hF, 8'h20, 32'h1, 1'b0, 4'h0, 8'h0, 32'h0);
        step(1'b1, 1'b1, 4'hF, 8'h20, 32'h2, 1'b0, 4'h0, 8'h0, 32'h0);
        chk("rdw read-first", aq[0], 32'h1);
        chk("rdw no-change valid", 32'(av[2]), 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
        chk("rdw write-first", aq[1], 32'h2);

        // cross-port: other port sees old word, then new
        step(1'b1, 1'b1, 4'hF, 8'h30, 32'h55, 1'b1, 4'h0, 8'h30, 32'h0);
        chk("cross old", bq[0], 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 4'h0, 8'h30, 32'h0);
        chk("cross new", bq[0], 32'h55);

        // collisions: overlapping then disjoint lanes
        step(1'b1, 1'b1, 4'b0001, 8'h40, 32'h000000AA, 1'b1, 4'b0011, 8'h40, 32'h0000BBCC);
        chk("collision overlap", 32'(col[0]), 32'h1);
        step(1'b1, 1'b1, 4'h0, 8'h40, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
        chk("collision pulse end", 32'(col[0]), 32'h0);
        chk("collision merge", aq[0], 32'h0000BBAA);
        step(1'b1, 1'b1, 4'b0001, 8'h41, 32'h000000AA, 1'b1, 4'b0010, 8'h41, 32'h0000BBCC);
        chk("collision disjoint", 32'(col[0]), 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 4'h0, 8'h41, 32'h0);
        chk("disjoint merge", bq[0], 32'h0000BBAA);

        // streaming random traffic, then a mid-stream reset and more traffic
        random_phase(256);
        do_reset(2);
        random_phase(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
